// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host master and its users.
package wb_host_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    // Multi-project harness register map, for benches and command sources
    localparam logic [WB_ADR_W-1:0] WB_PROJ_SEL_ADR   = 32'h3000_0000;
    localparam logic [WB_ADR_W-1:0] WB_PROJ_REG_A_ADR = 32'h3000_0100;
    localparam logic [WB_ADR_W-1:0] WB_PROJ_REG_B_ADR = 32'h3000_0200;
    localparam logic [WB_ADR_W-1:0] WB_PROJ_REG_C_ADR = 32'h3000_0400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_host_if.sv
// Command, response and Wishbone initiator signals of the host master.
interface wb_host_if;
    import wb_host_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [WB_SEL_W-1:0] cmd_sel;
    logic [WB_ADR_W-1:0] cmd_adr;
    logic [WB_DAT_W-1:0] cmd_dat;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WB_DAT_W-1:0] rsp_dat;
    logic                rsp_err;

    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [WB_SEL_W-1:0] wbm_sel_o;
    logic [WB_ADR_W-1:0] wbm_adr_o;
    logic [WB_DAT_W-1:0] wbm_dat_o;
    logic [WB_DAT_W-1:0] wbm_dat_i;
    logic                wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
               wbm_dat_i, wbm_ack_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
               wbm_dat_i, wbm_ack_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog: counts waiting cycles and flags the edge on which the limit is reached.
module wb_host_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // High on the waiting edge that would take the count to TIMEOUT_CYCLES
    assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/wb_host_master.sv
// Single-beat Wishbone classic initiator fed by a command/response handshake.
// Define WB_HOST_MASTER_TIMEOUT_EN to abort unanswered cycles after TIMEOUT_CYCLES.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic    wb_clk_i,
    input  logic    wb_rst_i,
    wb_host_if.master bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_host_master: TIMEOUT_CYCLES must be within 2..65535");
    end

    wb_state_e           state_reg;
    wb_state_e           state_next;
    logic                accept;
    logic                bus_done;
    logic                timed_out;
    logic                cmd_ready;
    logic                rsp_valid;
    logic                cyc;
    logic                we_reg;
    logic [WB_SEL_W-1:0] sel_reg;
    logic [WB_ADR_W-1:0] adr_reg;
    logic [WB_DAT_W-1:0] dat_reg;
    logic [WB_DAT_W-1:0] rsp_dat_reg;

    assign accept   = (state_reg == ST_IDLE) && bus.cmd_valid;
    assign bus_done = (state_reg == ST_BUS) && (bus.wbm_ack_i || timed_out);

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    logic bus_wait;
    logic rsp_err_reg;

    assign bus_wait = (state_reg == ST_BUS) && !bus.wbm_ack_i;

    wb_host_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .srst    (wb_rst_i),
        .clear   (accept),
        .enable  (bus_wait),
        .expired (timed_out)
    );

    // An ack on the expiry edge still completes normally
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rsp_err_reg <= 1'b0;
        end else if (bus_done) begin
            rsp_err_reg <= !bus.wbm_ack_i;
        end
    end

    assign bus.rsp_err = rsp_err_reg;
`else
    assign timed_out   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.cmd_valid)                    state_next = ST_BUS;
            ST_BUS:  if (bus.wbm_ack_i || timed_out)       state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready)                    state_next = ST_IDLE;
            default:                                       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_reg == ST_IDLE) && !wb_rst_i;
        rsp_valid = (state_reg == ST_RESP);
        cyc       = (state_reg == ST_BUS);
    end

    // Request fields are held after the cycle; only cyc/stb qualify them
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_reg      <= 1'b0;
            sel_reg     <= '0;
            adr_reg     <= '0;
            dat_reg     <= '0;
            rsp_dat_reg <= '0;
        end else begin
            if (accept) begin
                we_reg  <= bus.cmd_we;
                sel_reg <= bus.cmd_sel;
                adr_reg <= bus.cmd_adr;
                dat_reg <= bus.cmd_dat;
            end
            if (bus_done) begin
                rsp_dat_reg <= (bus.wbm_ack_i && !we_reg) ? bus.wbm_dat_i : '0;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_dat   = rsp_dat_reg;
    assign bus.wbm_cyc_o = cyc;
    assign bus.wbm_stb_o = cyc;
    assign bus.wbm_we_o  = we_reg;
    assign bus.wbm_sel_o = sel_reg;
    assign bus.wbm_adr_o = adr_reg;
    assign bus.wbm_dat_o = dat_reg;

endmodule
